// File: rtl/dt_cp_seq_if.sv
// Handshake and buffer-port bundle between the copy sequencer and its surroundings.
// master: the sequencer side. slave: the APB block / buffer-wrapper side.
interface dt_cp_seq_if #(
  parameter int unsigned P_AW = 9,
  parameter int unsigned P_DW = 32
);
  logic            iStDtCp;
  logic [P_AW:0]   iPktWdSize;
  logic            oRdEn_InBuf;
  logic [P_AW-1:0] oRdAddr_InBuf;
  logic [P_DW-1:0] iRdDt_InBuf;
  logic            oWrEn_OutBuf;
  logic [P_AW-1:0] oWrAddr_OutBuf;
  logic [P_DW-1:0] oWrDt_OutBuf;
  logic            oBusy;
  logic            oDtCpDone;
  logic            oSizeErr;

  modport master (
    input  iStDtCp, iPktWdSize, iRdDt_InBuf,
    output oRdEn_InBuf, oRdAddr_InBuf, oWrEn_OutBuf, oWrAddr_OutBuf, oWrDt_OutBuf,
           oBusy, oDtCpDone, oSizeErr
  );

  modport slave (
    output iStDtCp, iPktWdSize, iRdDt_InBuf,
    input  oRdEn_InBuf, oRdAddr_InBuf, oWrEn_OutBuf, oWrAddr_OutBuf, oWrDt_OutBuf,
           oBusy, oDtCpDone, oSizeErr
  );
endinterface

// File: rtl/dt_cp_seq.sv
// Packet copy sequencer: reads N words from InBuf, transforms each, writes them to OutBuf.
// Optional build macro DT_CP_TWOS_CMP_EN: when defined each word is 2's-complemented,
// otherwise it is copied unchanged. Timing is identical in both builds.
module dt_cp_seq #(
  parameter int unsigned P_AW = 9,
  parameter int unsigned P_DW = 32
) (
  input logic          iClk,
  input logic          iRsn,
  dt_cp_seq_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StRd, StDrain, StDone} state_e;

  // Largest legal packet: the full buffer depth.
  localparam logic [P_AW:0] MaxSize = {1'b1, {P_AW{1'b0}}};

  state_e          state_q, state_d;
  logic [P_AW:0]   size_q, size_d;
  logic            clamp_q, clamp_d;
  logic [P_AW:0]   cnt_q, cnt_d;
  logic            drain_q, drain_d;
  logic            rd_en_q, rd_en_d;
  logic [P_AW-1:0] rd_addr_q, rd_addr_d;
  logic            rd_vld_q;
  logic [P_AW-1:0] rd_addr_dly_q;
  logic            wr_en_q;
  logic [P_AW-1:0] wr_addr_q;
  logic [P_DW-1:0] wr_dt_q, wr_dt_d;
  logic            busy_q, done_q, size_err_q;

  function automatic logic [P_DW-1:0] xform(input logic [P_DW-1:0] x);
`ifdef DT_CP_TWOS_CMP_EN
    return ~x + {{(P_DW-1){1'b0}}, 1'b1};
`else
    return x;
`endif
  endfunction

  // Next-state, size latch and read-address generation.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    clamp_d   = clamp_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.iStDtCp) begin
          if (bus.iPktWdSize > MaxSize) begin
            size_d  = MaxSize;
            clamp_d = 1'b1;
          end else begin
            size_d  = bus.iPktWdSize;
            clamp_d = 1'b0;
          end
          if (bus.iPktWdSize == '0) begin
            state_d = StDone;
          end else begin
            // First read issues on the same edge that leaves idle.
            state_d   = StRd;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            cnt_d     = {{P_AW{1'b0}}, 1'b1};
          end
        end
      end
      StRd: begin
        // cnt_q counts reads already issued; stop once all N are out.
        if (cnt_q == size_q) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q[P_AW-1:0];
          cnt_d     = cnt_q + {{P_AW{1'b0}}, 1'b1};
        end
      end
      StDrain: begin
        // Two cycles let the last read return and be written.
        drain_d = 1'b1;
        if (drain_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Write data is captured only when a read returns.
  always_comb begin
    wr_dt_d = wr_dt_q;
    if (rd_vld_q) wr_dt_d = xform(bus.iRdDt_InBuf);
  end

  // State, registered outputs and the two-stage read-to-write pipeline.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q       <= StIdle;
      size_q        <= '0;
      clamp_q       <= 1'b0;
      cnt_q         <= '0;
      drain_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      rd_vld_q      <= 1'b0;
      rd_addr_dly_q <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_dt_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      size_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      clamp_q       <= clamp_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      rd_vld_q      <= rd_en_q;
      rd_addr_dly_q <= rd_addr_q;
      wr_en_q       <= rd_vld_q;
      wr_addr_q     <= rd_addr_dly_q;
      wr_dt_q       <= wr_dt_d;
      busy_q        <= (state_d != StIdle);
      done_q        <= (state_d == StDone);
      size_err_q    <= (state_d == StDone) && clamp_d;
    end
  end

  assign bus.oRdEn_InBuf    = rd_en_q;
  assign bus.oRdAddr_InBuf  = rd_addr_q;
  assign bus.oWrEn_OutBuf   = wr_en_q;
  assign bus.oWrAddr_OutBuf = wr_addr_q;
  assign bus.oWrDt_OutBuf   = wr_dt_q;
  assign bus.oBusy          = busy_q;
  assign bus.oDtCpDone      = done_q;
  assign bus.oSizeErr       = size_err_q;

endmodule

// File: tb/tb_dt_cp_seq.sv
// Bench for dt_cp_seq: InBuf/OutBuf models, cycle-by-cycle timing expectations from the
// packet size, and a final OutBuf content check.
module tb_dt_cp_seq;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int          DEPTH = 512;

  logic clk = 1'b0;
  logic rsn;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   wr_cnt = 0;
  logic [31:0] inbuf  [DEPTH];
  logic [31:0] outbuf [DEPTH];

  dt_cp_seq_if #(.P_AW(AW), .P_DW(DW)) bus ();

  dt_cp_seq #(.P_AW(AW), .P_DW(DW)) u_dut (
    .iClk (clk),
    .iRsn (rsn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // InBuf: registered read, data one clock after the enable.
  always @(posedge clk) begin
    if (bus.oRdEn_InBuf) bus.iRdDt_InBuf <= inbuf[bus.oRdAddr_InBuf];
  end

  function automatic logic [31:0] f(input logic [31:0] x);
`ifdef DT_CP_TWOS_CMP_EN
    return 32'd0 - x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.oRdEn_InBuf), 32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.oRdAddr_InBuf), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.oWrEn_OutBuf), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.oWrAddr_OutBuf), 32'd0);
    chk({tag, "_wr_dt"}, bus.oWrDt_OutBuf, 32'd0);
    chk({tag, "_busy"}, 32'(bus.oBusy), 32'd0);
    chk({tag, "_done"}, 32'(bus.oDtCpDone), 32'd0);
    chk({tag, "_size_err"}, 32'(bus.oSizeErr), 32'd0);
  endtask

  // Expected outputs in cycle c of a copy of n words (start sampled at edge 0).
  task automatic chk_cycle(input int c, input int n, input bit clamped);
    bit exp_rd, exp_wr, exp_busy, exp_done;
    int done_c;
    done_c   = (n == 0) ? 1 : n + 3;
    exp_rd   = (c >= 1) && (c <= n);
    exp_wr   = (c >= 3) && (c <= n + 2);
    exp_busy = (c >= 1) && (c <= done_c);
    exp_done = (c == done_c);
    chk("rd_en", 32'(bus.oRdEn_InBuf), 32'(exp_rd));
    if (exp_rd) chk("rd_addr", 32'(bus.oRdAddr_InBuf), 32'(c - 1));
    chk("wr_en", 32'(bus.oWrEn_OutBuf), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_addr", 32'(bus.oWrAddr_OutBuf), 32'(c - 3));
      chk("wr_dt", bus.oWrDt_OutBuf, f(inbuf[c - 3]));
    end
    chk("busy", 32'(bus.oBusy), 32'(exp_busy));
    chk("done", 32'(bus.oDtCpDone), 32'(exp_done));
    chk("size_err", 32'(bus.oSizeErr), 32'(exp_done && clamped));
    if (bus.oWrEn_OutBuf) begin
      outbuf[bus.oWrAddr_OutBuf] = bus.oWrDt_OutBuf;
      wr_cnt++;
    end
  endtask

  // One copy. ign_c: cycle in which a second (ignored) start is driven; rst_c: cycle in
  // which reset is asserted (copy abandoned). 0 disables either.
  task automatic run(input int size, input int ign_c, input int rst_c);
    int  n, last;
    bit  clamped, aborted;
    clamped = (size > DEPTH);
    n       = clamped ? DEPTH : size;
    last    = ((n == 0) ? 1 : n + 3) + 1;
    aborted = 1'b0;
    wr_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) outbuf[i] = ~f(inbuf[i]);
    bus.iPktWdSize = 10'(size);
    bus.iStDtCp    = 1'b1;
    step();
    bus.iStDtCp    = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (c == rst_c) begin
        rsn = 1'b0;
        #1;
        chk_all_zero("rst_async");
        step();
        chk_all_zero("rst_hold");
        step();
        chk_all_zero("rst_hold2");
        rsn = 1'b1;
        aborted = 1'b1;
        break;
      end
      chk_cycle(c, n, clamped);
      if (c == last) break;
      if (c == ign_c) begin
        bus.iStDtCp    = 1'b1;
        bus.iPktWdSize = 10'd2;
      end
      step();
      bus.iStDtCp = 1'b0;
    end
    if (!aborted) begin
      chk("wr_count", 32'(wr_cnt), 32'(n));
      for (int i = 0; i < n; i++) chk("outbuf", outbuf[i], f(inbuf[i]));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) inbuf[i] = $urandom;
  endtask

  initial begin
    rsn            = 1'b0;
    bus.iStDtCp    = 1'b0;
    bus.iPktWdSize = '0;
    fill_random();
    #1;
    chk_all_zero("reset");
    step();
    step();
    rsn = 1'b1;
    step();
    chk_all_zero("idle");

    // Directed 4-word packet including the 2's-complement corner values.
    inbuf[0] = 32'h0000_0001;
    inbuf[1] = 32'h0000_0000;
    inbuf[2] = 32'h7FFF_FFFF;
    inbuf[3] = 32'h8000_0000;
    run(4, 0, 0);
`ifdef DT_CP_TWOS_CMP_EN
    chk("vec4_w0", outbuf[0], 32'hFFFF_FFFF);
    chk("vec4_w1", outbuf[1], 32'h0000_0000);
    chk("vec4_w2", outbuf[2], 32'h8000_0001);
    chk("vec4_w3", outbuf[3], 32'h8000_0000);
`else
    chk("vec4_w0", outbuf[0], 32'h0000_0001);
    chk("vec4_w2", outbuf[2], 32'h7FFF_FFFF);
    chk("vec4_w3", outbuf[3], 32'h8000_0000);
`endif

    // Empty packet.
    run(0, 0, 0);

    // Oversize packets clamp to the full buffer; exactly full does not flag.
    fill_random();
    run(600, 0, 0);
    run(512, 0, 0);
    run(513, 0, 0);

    // Start while busy is ignored; a start right after returning to idle is taken.
    fill_random();
    run(8, 4, 0);
    run(5, 0, 0);

    // Reset mid-copy abandons the packet; next copy behaves normally.
    run(16, 0, 6);
    run(1, 0, 0);

    // Plain-copy data vector.
    inbuf[0] = 32'h1234_5678;
    inbuf[1] = 32'hDEAD_BEEF;
    run(2, 0, 0);
`ifndef DT_CP_TWOS_CMP_EN
    chk("vec2_w0", outbuf[0], 32'h1234_5678);
    chk("vec2_w1", outbuf[1], 32'hDEAD_BEEF);
`else
    chk("vec2_w0", outbuf[0], 32'hEDCB_A988);
    chk("vec2_w1", outbuf[1], 32'h2152_4111);
`endif

    // Random sizes and data.
    for (int k = 0; k < 5; k++) begin
      fill_random();
      run(int'($urandom_range(1, 40)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
